// File: rtl/final_full_adder.sv
// WIDTH-bit ripple-carry adder with carry-in/carry-out and a single output register stage.
// Built from a chain of one-bit full-adder cells, LSB to MSB.

module final_full_adder_cell (
  input  logic i_a,
  input  logic i_b,
  input  logic i_c,
  output logic o_s,
  output logic o_c
);

  logic w_p;

  assign w_p = i_a ^ i_b;
  assign o_s = w_p ^ i_c;
  assign o_c = (i_a & i_b) | (i_c & w_p);

endmodule

module final_full_adder #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] s,
  output logic             cout
);

  logic [WIDTH:0]   w_carry;
  logic [WIDTH-1:0] w_sum;
  logic [WIDTH-1:0] r_s;
  logic             r_cout;

  assign w_carry[0] = cin;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    final_full_adder_cell u_cell (
      .i_a (a[i]),
      .i_b (b[i]),
      .i_c (w_carry[i]),
      .o_s (w_sum[i]),
      .o_c (w_carry[i+1])
    );
  end

  // Result register; reset wins over the load so an in-flight sum is discarded.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s    <= {WIDTH{1'b0}};
      r_cout <= 1'b0;
    end else begin
      r_s    <= w_sum;
      r_cout <= w_carry[WIDTH];
    end
  end

  assign s    = r_s;
  assign cout = r_cout;

endmodule

// File: tb/tb_final_full_adder.sv
// Scoreboard bench for final_full_adder at WIDTH=4, with WIDTH=1 and WIDTH=8 builds driven alongside.

module tb_final_full_adder;

  typedef struct {
    string      tag;
    logic [4:0] e4;
    logic [1:0] e1;
    logic [8:0] e8;
  } exp_t;

  logic       clk;
  logic       rst;
  logic [3:0] a4, b4;
  logic [0:0] a1, b1;
  logic [7:0] a8, b8;
  logic       cin;
  logic [3:0] s4;
  logic [0:0] s1;
  logic [7:0] s8;
  logic       cout4, cout1, cout8;

  exp_t q[$];
  exp_t cur;
  exp_t last;
  int   vectors;
  int   miscompares;

  final_full_adder #(.WIDTH(4)) dut (
    .clk(clk), .rst(rst), .a(a4), .b(b4), .cin(cin), .s(s4), .cout(cout4)
  );

  final_full_adder #(.WIDTH(1)) dut_w1 (
    .clk(clk), .rst(rst), .a(a1), .b(b1), .cin(cin), .s(s1), .cout(cout1)
  );

  final_full_adder #(.WIDTH(8)) dut_w8 (
    .clk(clk), .rst(rst), .a(a8), .b(b8), .cin(cin), .s(s8), .cout(cout8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input exp_t e);
    vectors++;
    assert ({cout4, s4} === e.e4) else begin
      miscompares++;
      $error("FAIL %s w4: got %h expected %h", tag, {cout4, s4}, e.e4);
    end
    vectors++;
    assert ({cout1, s1} === e.e1) else begin
      miscompares++;
      $error("FAIL %s w1: got %h expected %h", tag, {cout1, s1}, e.e1);
    end
    vectors++;
    assert ({cout8, s8} === e.e8) else begin
      miscompares++;
      $error("FAIL %s w8: got %h expected %h", tag, {cout8, s8}, e.e8);
    end
  endtask

  // Drive one cycle of operands, push the expected result, then pop and compare after the edge.
  task automatic step8(input string tag, input logic r, input logic [3:0] ta, input logic [3:0] tb,
                       input logic c, input logic [7:0] ta8, input logic [7:0] tb8);
    exp_t e;
    rst = r;
    a4  = ta;
    b4  = tb;
    a1  = ta[0:0];
    b1  = tb[0:0];
    a8  = ta8;
    b8  = tb8;
    cin = c;
    e.tag = tag;
    if (r) begin
      e.e4 = 5'h00;
      e.e1 = 2'b00;
      e.e8 = 9'h000;
    end else begin
      e.e4 = 5'(ta) + 5'(tb) + 5'(c);
      e.e1 = 2'(ta[0]) + 2'(tb[0]) + 2'(c);
      e.e8 = 9'(ta8) + 9'(tb8) + 9'(c);
    end
    q.push_back(e);
    @(posedge clk);
    #1;
    if (q.size() == 0) begin
      vectors++;
      miscompares++;
      $error("FAIL %s scoreboard: got empty queue expected one entry", tag);
    end else begin
      cur = q.pop_front();
      check(cur.tag, cur);
      last = cur;
    end
  endtask

  task automatic step(input string tag, input logic r, input logic [3:0] ta, input logic [3:0] tb,
                      input logic c);
    step8(tag, r, ta, tb, c, {ta, tb}, {tb ^ 4'h5, ta});
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst = 1'b1; a4 = 4'h0; b4 = 4'h0; a1 = 1'b0; b1 = 1'b0; a8 = 8'h00; b8 = 8'h00; cin = 1'b0;

    step("reset0", 1'b1, 4'hF, 4'hF, 1'b1);
    step("reset1", 1'b1, 4'hF, 4'hF, 1'b1);

    step("basic",   1'b0, 4'b1010, 4'b1000, 1'b0);
    step("ripple",  1'b0, 4'hF, 4'h0, 1'b1);
    step("ripple7", 1'b0, 4'h7, 4'h0, 1'b1);

    step("pipe0", 1'b0, 4'h3, 4'h4, 1'b0);
    step("pipe1", 1'b0, 4'hF, 4'hF, 1'b1);
    step("pipe2", 1'b0, 4'h0, 4'h0, 1'b0);

    step("mid_load", 1'b0, 4'h5, 4'h6, 1'b0);
    step("mid_rst",  1'b1, 4'h9, 4'h9, 1'b0);
    step("mid_rel",  1'b0, 4'h9, 4'h9, 1'b0);

    // A reset pulse between edges must leave the registered result untouched.
    #2 rst = 1'b1;
    #2 rst = 1'b0;
    check("rst_glitch", last);
    step("after_glitch", 1'b0, 4'hC, 4'h5, 1'b1);

    step8("w8_max",  1'b0, 4'hF, 4'hF, 1'b1, 8'hFF, 8'hFF);
    step8("w8_zero", 1'b0, 4'h0, 4'h0, 1'b0, 8'h80, 8'h80);

    for (int i = 0; i < 512; i++) begin
      logic [8:0] v;
      v = 9'(i);
      step("exhaustive", 1'b0, v[8:5], v[4:1], v[0]);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
